// File: rtl/xs_video_timing.sv
// xs_video_timing
// Raster timing generator. Horizontal and vertical pixel counters behave like
// LS163-style loadable counter chains: they advance on a detected rising edge
// of the pixel enable and preset-load on terminal count. The counter states
// are decoded into blanking, sync and line/frame strobes.
//
// Ports:
//   Clk       - system clock, all state on its rising edge
//   Reset     - synchronous, active-high
//   Cen       - pixel enable; a sampled 0->1 transition is one pixel tick
//   Run       - count enable; ticks are ignored while low
//   HCNT      - horizontal count (9 bit)
//   VCNT      - vertical count (9 bit)
//   HBLANK    - high outside the active pixels
//   VBLANK    - high outside the active lines
//   HSYNC_n   - active-low horizontal sync
//   VSYNC_n   - active-low vertical sync
//   LINE_END  - one-Clk pulse in the cycle after HCNT wraps
//   FRAME_END - one-Clk pulse in the cycle after HCNT and VCNT wrap together
module xs_video_timing #(
  parameter logic [8:0] H_LOAD     = 9'd128,
  parameter logic [8:0] H_END      = 9'd511,
  parameter logic [8:0] HACT_START = 9'd136,
  parameter logic [8:0] HACT_END   = 9'd392,
  parameter logic [8:0] HS_START   = 9'd408,
  parameter logic [8:0] HS_END     = 9'd440,
  parameter logic [8:0] V_LOAD     = 9'd248,
  parameter logic [8:0] V_END      = 9'd511,
  parameter logic [8:0] VACT_START = 9'd264,
  parameter logic [8:0] VACT_END   = 9'd504,
  parameter logic [8:0] VS_START   = 9'd250,
  parameter logic [8:0] VS_END     = 9'd253
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Cen,
  input  logic       Run,
  output logic [8:0] HCNT,
  output logic [8:0] VCNT,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       HSYNC_n,
  output logic       VSYNC_n,
  output logic       LINE_END,
  output logic       FRAME_END
);

  logic       last_cen_p0;
  logic [8:0] hcnt_p0;
  logic [8:0] vcnt_p0;
  logic       line_end_p1;
  logic       frame_end_p1;

  logic tick;
  logic adv;
  logic h_wrap;
  logic v_wrap;

  // Stage 0: Cen edge detect and counter advance
  assign tick   = Cen & ~last_cen_p0;
  assign adv    = tick & Run;
  assign h_wrap = (hcnt_p0 == H_END);
  assign v_wrap = (vcnt_p0 == V_END);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      // last_cen starts high so the first tick needs Cen seen low first
      last_cen_p0  <= 1'b1;
      hcnt_p0      <= H_LOAD;
      vcnt_p0      <= V_LOAD;
      line_end_p1  <= 1'b0;
      frame_end_p1 <= 1'b0;
    end else begin
      // Tracks Cen even while Run is low, so raising Run mid-pulse is not a tick
      last_cen_p0  <= Cen;
      // Stage 1: strobes registered from the wrap condition
      line_end_p1  <= adv & h_wrap;
      frame_end_p1 <= adv & h_wrap & v_wrap;
      if (adv) begin
        hcnt_p0 <= h_wrap ? H_LOAD : hcnt_p0 + 9'd1;
        if (h_wrap) begin
          vcnt_p0 <= v_wrap ? V_LOAD : vcnt_p0 + 9'd1;
        end
      end
    end
  end

  assign HCNT      = hcnt_p0;
  assign VCNT      = vcnt_p0;
  assign LINE_END  = line_end_p1;
  assign FRAME_END = frame_end_p1;

  // Decodes are combinational from the current counts (non-wrapping windows)
  assign HBLANK  = (hcnt_p0 < HACT_START) | (hcnt_p0 >= HACT_END);
  assign HSYNC_n = ~((hcnt_p0 >= HS_START) & (hcnt_p0 < HS_END));
  assign VBLANK  = (vcnt_p0 < VACT_START) | (vcnt_p0 >= VACT_END);
  assign VSYNC_n = ~((vcnt_p0 >= VS_START) & (vcnt_p0 < VS_END));

endmodule

// File: tb/tb_xs_video_timing.sv
module tb_xs_video_timing;

  logic Clk;
  logic Reset;
  logic Cen;
  logic Run;

  // Default-parameter instance
  logic [8:0] d_hcnt, d_vcnt;
  logic d_hblank, d_vblank, d_hsync_n, d_vsync_n, d_line_end, d_frame_end;

  // Shrunk-raster instance: 12 ticks/line (500..511), 7 lines/frame (505..511)
  logic [8:0] s_hcnt, s_vcnt;
  logic s_hblank, s_vblank, s_hsync_n, s_vsync_n, s_line_end, s_frame_end;

  int total;
  int bad;

  xs_video_timing u_dut (
    .Clk(Clk), .Reset(Reset), .Cen(Cen), .Run(Run),
    .HCNT(d_hcnt), .VCNT(d_vcnt), .HBLANK(d_hblank), .VBLANK(d_vblank),
    .HSYNC_n(d_hsync_n), .VSYNC_n(d_vsync_n),
    .LINE_END(d_line_end), .FRAME_END(d_frame_end)
  );

  xs_video_timing #(
    .H_LOAD(9'd500), .H_END(9'd511),
    .HACT_START(9'd502), .HACT_END(9'd508),
    .HS_START(9'd509), .HS_END(9'd511),
    .V_LOAD(9'd505), .V_END(9'd511),
    .VACT_START(9'd507), .VACT_END(9'd510),
    .VS_START(9'd506), .VS_END(9'd508)
  ) u_small (
    .Clk(Clk), .Reset(Reset), .Cen(Cen), .Run(Run),
    .HCNT(s_hcnt), .VCNT(s_vcnt), .HBLANK(s_hblank), .VBLANK(s_vblank),
    .HSYNC_n(s_hsync_n), .VSYNC_n(s_vsync_n),
    .LINE_END(s_line_end), .FRAME_END(s_frame_end)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, settle 1 time unit past it
  task automatic step(input logic c, input logic r, input logic rs);
    Cen = c;
    Run = r;
    Reset = rs;
    @(posedge Clk);
    #1;
  endtask

  task automatic pulse();
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    int hsync_low;
    int hact_cnt;
    int fe_cnt;
    logic [8:0] eh;
    logic [8:0] ev;
    total = 0;
    bad = 0;
    Cen = 1'b1;
    Run = 1'b1;
    Reset = 1'b1;

    // Reset with Cen high
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("rst_hcnt", d_hcnt, 9'd128);
    chk("rst_vcnt", d_vcnt, 9'd248);
    chk("rst_hblank", {8'd0, d_hblank}, 9'd1);
    chk("rst_hsync_n", {8'd0, d_hsync_n}, 9'd1);
    chk("rst_vblank", {8'd0, d_vblank}, 9'd1);
    chk("rst_vsync_n", {8'd0, d_vsync_n}, 9'd1);
    chk("rst_line_end", {8'd0, d_line_end}, 9'd0);
    chk("rst_frame_end", {8'd0, d_frame_end}, 9'd0);
    chk("rst_s_hcnt", s_hcnt, 9'd500);
    chk("rst_s_vcnt", s_vcnt, 9'd505);

    // Cen still high after reset: no tick until it is seen low
    step(1'b1, 1'b1, 1'b0);
    chk("hold_no_tick", d_hcnt, 9'd128);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("first_tick", d_hcnt, 9'd129);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0);
    chk("held_high_one_tick", d_hcnt, 9'd129);
    chk("held_high_small", s_hcnt, 9'd501);

    // Run low during 5 Cen pulses
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("runlo_hcnt", d_hcnt, 9'd129);
      chk("runlo_vcnt", d_vcnt, 9'd248);
      chk("runlo_line_end", {8'd0, d_line_end}, 9'd0);
    end
    // Raising Run while Cen is already high is not a tick
    step(1'b1, 1'b1, 1'b0);
    chk("run_mid_pulse", d_hcnt, 9'd129);

    // One full line on the default raster
    step(1'b0, 1'b1, 1'b1);
    hsync_low = 0;
    hact_cnt = 0;
    for (int i = 1; i <= 384; i++) begin
      pulse();
      if (i < 384) chk("line_hcnt", d_hcnt, 9'(128 + i));
      chk("line_le", {8'd0, d_line_end}, (i == 384) ? 9'd1 : 9'd0);
      chk("line_fe", {8'd0, d_frame_end}, 9'd0);
      if (!d_hsync_n) hsync_low++;
      if (!d_hblank) hact_cnt++;
      if (i == 7)   chk("hblank_135", {8'd0, d_hblank}, 9'd1);
      if (i == 8)   chk("hblank_136", {8'd0, d_hblank}, 9'd0);
      if (i == 263) chk("hblank_391", {8'd0, d_hblank}, 9'd0);
      if (i == 264) chk("hblank_392", {8'd0, d_hblank}, 9'd1);
      if (i == 279) chk("hsync_407", {8'd0, d_hsync_n}, 9'd1);
      if (i == 280) chk("hsync_408", {8'd0, d_hsync_n}, 9'd0);
      if (i == 311) chk("hsync_439", {8'd0, d_hsync_n}, 9'd0);
      if (i == 312) chk("hsync_440", {8'd0, d_hsync_n}, 9'd1);
    end
    chk("line_wrap_hcnt", d_hcnt, 9'd128);
    chk("line_wrap_vcnt", d_vcnt, 9'd249);
    chk("hsync_low_ticks", 9'(hsync_low), 9'd32);
    chk("hactive_ticks", 9'(hact_cnt), 9'd256);
    step(1'b0, 1'b1, 1'b0);
    chk("line_end_width", {8'd0, d_line_end}, 9'd0);
    chk("line_vcnt_hold", d_vcnt, 9'd249);

    // Full frame on the shrunk raster (84 ticks)
    step(1'b0, 1'b1, 1'b1);
    fe_cnt = 0;
    for (int i = 1; i <= 84; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("frm_le_low", {8'd0, s_line_end}, 9'd0);
      step(1'b1, 1'b1, 1'b0);
      eh = 9'(500 + (i % 12));
      ev = 9'(505 + ((i / 12) % 7));
      chk("frm_hcnt", s_hcnt, eh);
      chk("frm_vcnt", s_vcnt, ev);
      chk("frm_le", {8'd0, s_line_end}, (i % 12 == 0) ? 9'd1 : 9'd0);
      chk("frm_fe", {8'd0, s_frame_end}, (i == 84) ? 9'd1 : 9'd0);
      chk("frm_hblank", {8'd0, s_hblank}, (eh >= 9'd502 && eh < 9'd508) ? 9'd0 : 9'd1);
      chk("frm_hsync_n", {8'd0, s_hsync_n}, (eh >= 9'd509 && eh < 9'd511) ? 9'd0 : 9'd1);
      chk("frm_vblank", {8'd0, s_vblank}, (ev >= 9'd507 && ev < 9'd510) ? 9'd0 : 9'd1);
      chk("frm_vsync_n", {8'd0, s_vsync_n}, (ev >= 9'd506 && ev < 9'd508) ? 9'd0 : 9'd1);
      if (s_frame_end) begin
        fe_cnt++;
        chk("fe_with_le", {8'd0, s_line_end}, 9'd1);
      end
    end
    chk("frame_end_count", 9'(fe_cnt), 9'd1);
    chk("frm_d_hcnt", d_hcnt, 9'd212);
    chk("frm_d_vcnt", d_vcnt, 9'd248);

    // Reset coincident with a tick at HCNT=511, VCNT=511
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 83; i++) pulse();
    chk("pre_rst_hcnt", s_hcnt, 9'd511);
    chk("pre_rst_vcnt", s_vcnt, 9'd511);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("rst_tick_hcnt", s_hcnt, 9'd500);
    chk("rst_tick_vcnt", s_vcnt, 9'd505);
    chk("rst_tick_le", {8'd0, s_line_end}, 9'd0);
    chk("rst_tick_fe", {8'd0, s_frame_end}, 9'd0);
    step(1'b0, 1'b1, 1'b0);
    chk("post_rst_le", {8'd0, s_line_end}, 9'd0);
    chk("post_rst_fe", {8'd0, s_frame_end}, 9'd0);
    chk("post_rst_hcnt", s_hcnt, 9'd500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xs_video_timing.md
# xs_video_timing

Raster timing generator for the video section. It implements the horizontal and vertical pixel-counter chains as synchronous loadable counters clocked by the shared pixel enable. It decodes the counter states into blanking, sync and line/frame strobes. Its HCNT/VCNT buses and strobes feed the sprite/tile line engines and the video output stage. Counting matches the LS163-style chains used elsewhere in the design: increment on a detected Cen rising edge, with a preset load on terminal count.

## Interface
Parameters (all 9-bit values):
- H_LOAD, 9'd128: value loaded into HCNT after H_END.
- H_END, 9'd511: last HCNT value of a line (384 pixels/line with defaults).
- HACT_START, 9'd136: first active pixel.
- HACT_END, 9'd392: first blanked pixel after the active region (256 active).
- HS_START, 9'd408: first HCNT with HSYNC_n low.
- HS_END, 9'd440: first HCNT with HSYNC_n high again.
- V_LOAD, 9'd248: value loaded into VCNT after V_END.
- V_END, 9'd511: last line (264 lines/frame).
- VACT_START, 9'd264: first active line.
- VACT_END, 9'd504: first blanked line after the active region (240 active).
- VS_START, 9'd250: first VCNT with VSYNC_n low.
- VS_END, 9'd253: first VCNT with VSYNC_n high again.

Ports:
- Clk, input, 1: system clock; all state updates on its rising edge.
- Reset, input, 1: synchronous, active-high reset.
- Cen, input, 1: pixel enable. A 0→1 transition, sampled on Clk, is one pixel tick.
- Run, input, 1: count enable (ENT·ENP equivalent). When low, ticks are ignored.
- HCNT, output, 9: horizontal count.
- VCNT, output, 9: vertical count.
- HBLANK, output, 1: high outside the active pixels.
- VBLANK, output, 1: high outside the active lines.
- HSYNC_n, output, 1: active-low horizontal sync.
- VSYNC_n, output, 1: active-low vertical sync.
- LINE_END, output, 1: one-Clk pulse when HCNT wraps.
- FRAME_END, output, 1: one-Clk pulse when HCNT and VCNT wrap together.

## Operation
- Edge detect: last_cen is registered from Cen every Clk. tick = Cen & ~last_cen.
- Horizontal counter, on tick & Run:
  - if HCNT == H_END, HCNT ← H_LOAD;
  - otherwise HCNT ← HCNT + 1 (9-bit).
- Vertical counter, on tick & Run & (HCNT == H_END):
  - if VCNT == V_END, VCNT ← V_LOAD;
  - otherwise VCNT ← VCNT + 1.
- VCNT never changes on any other tick.
- Decodes are combinational from the current counters, so they change on the same Clk edge as the counts:
  - HBLANK = (HCNT < HACT_START) | (HCNT ≥ HACT_END)
  - HSYNC_n = ~((HCNT ≥ HS_START) & (HCNT < HS_END))
  - VBLANK = (VCNT < VACT_START) | (VCNT ≥ VACT_END)
  - VSYNC_n = ~((VCNT ≥ VS_START) & (VCNT < VS_END))
- LINE_END: registered. High for exactly the one Clk after the edge that loaded H_LOAD; low otherwise.
- FRAME_END: registered. High for exactly the one Clk after the edge that loaded both H_LOAD and V_LOAD.
- Run low:
  - counters and strobes hold (strobes 0);
  - last_cen keeps tracking Cen, so raising Run mid-pulse of Cen does not create a tick.
- Windows are non-wrapping. Parameters must satisfy LOAD < START ≤ END ≤ END-of-count; out-of-order windows are not supported.

## Timing
- Reset values, applied at the first Clk with Reset high:
  - HCNT = H_LOAD, VCNT = V_LOAD;
  - last_cen = 1 (a tick requires Cen seen low, then high);
  - LINE_END = FRAME_END = 0.
- Decoded outputs at reset, with defaults: HBLANK = 1, HSYNC_n = 1, VBLANK = 1, VSYNC_n = 1.
- Reset has priority over a simultaneous tick. Reset mid-line or mid-frame returns immediately to the reset values, with no strobe.
- Latency, tick detection to count update: HCNT/VCNT take the new value at the same Clk edge that samples Cen high with last_cen low. Decodes follow combinationally.
- Strobes lag the counter wrap by zero cycles in value: they are registered from the wrap condition and are visible during the Clk cycle after the wrap edge.
- Period, with defaults:
  - line = 384 ticks;
  - frame = 384 × 264 = 101 376 ticks.
- A Cen held high for many Clks yields one tick. Cen toggling every Clk yields a tick every 2 Clks; this is the maximum rate.

## Test plan
- Reset, then Cen toggling 0/1 each Clk, Run = 1:
  - HCNT steps 128→129… every 2 Clks;
  - after 384 ticks, HCNT = 128 and LINE_END pulses for 1 Clk;
  - VCNT = 249.
- HBLANK boundaries: HBLANK falls when HCNT becomes 136 and rises when HCNT becomes 392.
- HSYNC_n boundaries: HSYNC_n is low exactly for HCNT 408..439 (32 ticks).
- Full frame, 101 376 ticks:
  - VCNT sequence 248..511 → 248;
  - FRAME_END pulses once, coincident with a LINE_END pulse;
  - VSYNC_n low for VCNT 250..252;
  - VBLANK low for VCNT 264..503.
- Cen held high 10 Clks after reset: exactly one tick, HCNT = 129. Run = 0 during 5 Cen pulses: HCNT and VCNT unchanged, no strobes.
- Reset asserted on the same Clk as a tick at HCNT = 511, VCNT = 511: next state HCNT = 128, VCNT = 248, LINE_END = FRAME_END = 0.
